// File: rtl/dom_sbox_scheduler_if.sv
// Handshake and S-box bus bundle for dom_sbox_scheduler.
// The slave modport is the scheduler's view; master is the surrounding system.
interface dom_sbox_scheduler_if #(
  parameter int SHARES     = 2,
  parameter int RAND_WIDTH = 18
);
  logic                  InValidxSI;
  logic                  InReadyxSO;
  logic [8*SHARES-1:0]   InDataxDI;
  logic                  RandValidxSI;
  logic                  RandReadyxSO;
  logic [RAND_WIDTH-1:0] RandxDI;
  logic                  SboxEnxSO;
  logic [8*SHARES-1:0]   SboxInxDO;
  logic [RAND_WIDTH-1:0] SboxRandxDO;
  logic [8*SHARES-1:0]   SboxOutxDI;
  logic                  OutValidxSO;
  logic                  OutReadyxSI;
  logic [8*SHARES-1:0]   OutDataxDO;
  logic                  BusyxSO;

  modport slave (
    input  InValidxSI, InDataxDI, RandValidxSI, RandxDI, SboxOutxDI, OutReadyxSI,
    output InReadyxSO, RandReadyxSO, SboxEnxSO, SboxInxDO, SboxRandxDO,
           OutValidxSO, OutDataxDO, BusyxSO
  );

  modport master (
    output InValidxSI, InDataxDI, RandValidxSI, RandxDI, SboxOutxDI, OutReadyxSI,
    input  InReadyxSO, RandReadyxSO, SboxEnxSO, SboxInxDO, SboxRandxDO,
           OutValidxSO, OutDataxDO, BusyxSO
  );
endinterface

// File: rtl/dom_sbox_scheduler.sv
// Credit-based issue scheduler for a free-running pipelined DOM-masked AES S-box.
// Optional macro DOM_SCHED_PERF_CNT_EN adds issue/stall performance counters.
module dom_sbox_scheduler #(
  parameter int SHARES     = 2,
  parameter int LATENCY    = 4,
  parameter int RAND_WIDTH = 18,
  parameter int OUT_DEPTH  = 8
) (
  input  logic                ClkxCI,
  input  logic                RstxRI,
  dom_sbox_scheduler_if.slave bus
`ifdef DOM_SCHED_PERF_CNT_EN
  ,
  output logic [15:0]         IssueCntxDO,
  output logic [15:0]         StallCntxDO
`endif
);
  localparam int DW     = 8 * SHARES;
  localparam int PTR_W  = $clog2(OUT_DEPTH);
  localparam int FCNT_W = $clog2(OUT_DEPTH + 1);
  localparam int CNT_W  = $clog2(OUT_DEPTH + LATENCY + 1);

  logic [LATENCY-1:0] vsr;
  logic [DW-1:0]      mem [OUT_DEPTH];
  logic [PTR_W-1:0]   wrPtr, rdPtr;
  logic [FCNT_W-1:0]  fifoCnt;
  logic [CNT_W-1:0]   inflightCnt;
  logic               creditOk, issue, push, pop;

  // NOTE: combinational blocks use blocking '=' with a default first so no latch is inferred.
  always_comb begin
    inflightCnt = '0;
    for (int i = 0; i < LATENCY; i++) inflightCnt = inflightCnt + CNT_W'(vsr[i]);
  end

  // Every in-flight byte already owns a FIFO slot, so a push can never overflow.
  assign creditOk = (inflightCnt + CNT_W'(fifoCnt)) < CNT_W'(OUT_DEPTH);
  assign issue    = bus.InValidxSI & bus.RandValidxSI & creditOk & ~RstxRI;

  assign bus.InReadyxSO   = issue;
  assign bus.RandReadyxSO = issue;
  assign bus.SboxEnxSO    = issue;
  // Idle cycles feed zeros so stale shares never meet in the masked datapath.
  assign bus.SboxInxDO    = issue ? bus.InDataxDI : {DW{1'b0}};
  assign bus.SboxRandxDO  = issue ? bus.RandxDI : {RAND_WIDTH{1'b0}};

  generate
    if (LATENCY == 1) begin : g_vsr1
      always_ff @(posedge ClkxCI) vsr <= RstxRI ? 1'b0 : issue;
    end else begin : g_vsrN
      always_ff @(posedge ClkxCI) begin
        if (RstxRI) vsr <= '0;
        else        vsr <= {vsr[LATENCY-2:0], issue};
      end
    end
  endgenerate

  assign push = vsr[LATENCY-1];
  assign pop  = (fifoCnt != '0) & bus.OutReadyxSI;

  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      fifoCnt <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifoCnt <= fifoCnt + FCNT_W'(1);
        2'b01:   fifoCnt <= fifoCnt - FCNT_W'(1);
        default: fifoCnt <= fifoCnt;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; fifoCnt alone marks which entries are live.
  always_ff @(posedge ClkxCI) begin
    if (push) mem[wrPtr] <= bus.SboxOutxDI;
  end

  always_ff @(posedge ClkxCI) begin
    if (!RstxRI) assert (!(push && !pop && fifoCnt == FCNT_W'(OUT_DEPTH)));
  end

  assign bus.OutValidxSO = fifoCnt != '0;
  assign bus.OutDataxDO  = mem[rdPtr];
  assign bus.BusyxSO     = (|vsr) | (fifoCnt != '0);

`ifdef DOM_SCHED_PERF_CNT_EN
  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      IssueCntxDO <= '0;
      StallCntxDO <= '0;
    end else begin
      if (issue)                    IssueCntxDO <= IssueCntxDO + 16'd1;
      if (bus.InValidxSI && !issue) StallCntxDO <= StallCntxDO + 16'd1;
    end
  end
`endif
endmodule
